// File: rtl/uart_rx_frontend_if.sv
// rtl/uart_rx_frontend_if.sv - processor read-path bundle for the UART receive front end
interface uart_rx_frontend_if;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  // processor side: issues the read acknowledge, observes data and status
  modport master (
    output rd,
    input  rx_data,
    input  rx_ready,
    input  frame_err,
    input  overrun
  );

  // receiver side: owns data and status, consumes the read acknowledge
  modport slave (
    input  rd,
    output rx_data,
    output rx_ready,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 16x oversampling 8N1 receiver with one-byte holding register and sticky status
module uart_rx_frontend #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int DIV    = CLK_HZ / (BAUD * 16)
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               UART_RX,
  uart_rx_frontend_if.slave  bus
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          rx_meta;
  logic          rxs;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [3:0]    scnt;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;

  logic [7:0]    rx_data_q;
  logic          rx_ready_q;
  logic          frame_err_q;
  logic          overrun_q;

  // decoded events from the receive FSM
  logic          start_go;
  logic          start_mid;
  logic          bit_sample;
  logic          byte_done;
  logic          frame_bad;

  assign tick = (tcnt == TW'(DIV - 1));

  // two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rxs     <= rx_meta;
    end
  end

  // FSM state register
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: start detect, mid-start glitch filter, 8 data bits, stop check, break wait
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (!rxs) state_nxt = S_START;
      end
      S_START: begin
        if (tick && scnt == 4'd7) state_nxt = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick && scnt == 4'd15 && bcnt == 3'd7) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (tick && scnt == 4'd15) state_nxt = rxs ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: single-cycle event strobes that drive the datapath
  always_comb begin
    start_go   = 1'b0;
    start_mid  = 1'b0;
    bit_sample = 1'b0;
    byte_done  = 1'b0;
    frame_bad  = 1'b0;
    unique case (state)
      S_IDLE:  start_go   = !rxs;
      S_START: start_mid  = tick && (scnt == 4'd7);
      S_DATA:  bit_sample = tick && (scnt == 4'd15);
      S_STOP: begin
        byte_done = tick && (scnt == 4'd15) && rxs;
        frame_bad = tick && (scnt == 4'd15) && !rxs;
      end
      S_BREAK: ;
      default: ;
    endcase
  end

  // oversample divider plus sample/bit counters; realigned to the start edge so
  // every later sample lands mid-bit
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tcnt <= '0;
      scnt <= 4'd0;
      bcnt <= 3'd0;
    end else begin
      if (start_go || tick) tcnt <= '0;
      else                  tcnt <= tcnt + TW'(1);

      if (start_go || start_mid) scnt <= 4'd0;
      else if (tick)             scnt <= scnt + 4'd1;

      if (start_mid)       bcnt <= 3'd0;
      else if (bit_sample) bcnt <= bcnt + 3'd1;
    end
  end

  // LSB-first assembly of the incoming character
  always_ff @(posedge sysclk) begin
    if (reset) begin
      shreg <= 8'h00;
    end else if (bit_sample) begin
      shreg[bcnt] <= rxs;
    end
  end

  // holding register and status; a completing byte or bad stop bit takes
  // priority over a read acknowledge in the same cycle
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_data_q   <= 8'h00;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (byte_done) begin
        rx_data_q  <= shreg;
        rx_ready_q <= 1'b1;
        overrun_q  <= bus.rd ? 1'b0 : (overrun_q | rx_ready_q);
      end else if (bus.rd) begin
        rx_ready_q <= 1'b0;
        overrun_q  <= 1'b0;
      end

      if (frame_bad)   frame_err_q <= 1'b1;
      else if (bus.rd) frame_err_q <= 1'b0;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_ready  = rx_ready_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - directed and randomized bench for uart_rx_frontend against a byte-level model
module tb_uart_rx_frontend;

  localparam int BIT = 160;

  logic sysclk;
  logic reset;
  logic UART_RX;

  uart_rx_frontend_if bus ();

  uart_rx_frontend #(
    .CLK_HZ (1_600_000),
    .BAUD   (10_000)
  ) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .UART_RX (UART_RX),
    .bus     (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  // expected processor-visible state
  logic [7:0] m_data;
  logic       m_ready;
  logic       m_ferr;
  logic       m_ovr;

  int lat_cnt;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_good(input logic [7:0] b);
    if (m_ready) m_ovr = 1'b1;
    m_data  = b;
    m_ready = 1'b1;
  endtask

  task automatic model_bad();
    m_ferr = 1'b1;
  endtask

  task automatic model_rd();
    m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_data"},  int'(bus.rx_data),   int'(m_data));
    chk({tag, "_ready"}, int'(bus.rx_ready),  int'(m_ready));
    chk({tag, "_ferr"},  int'(bus.frame_err), int'(m_ferr));
    chk({tag, "_ovr"},   int'(bus.overrun),   int'(m_ovr));
  endtask

  task automatic do_rd();
    bus.rd = 1'b1;
    cyc(1);
    bus.rd = 1'b0;
    model_rd();
  endtask

  // start bit, 8 data bits LSB first, stop bit; the stop level is left on the line
  task automatic send_frame(input logic [7:0] b, input logic stop, input int period);
    UART_RX = 1'b0;
    cyc(period);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      cyc(period);
    end
    UART_RX = stop;
    cyc(period);
  endtask

  initial begin
    reset   = 1'b1;
    UART_RX = 1'b1;
    bus.rd  = 1'b0;
    model_reset();
    cyc(4);
    check_all("reset");
    reset = 1'b0;
    cyc(50);

    // frame 0x55 with start-edge to rx_ready latency
    fork
      send_frame(8'h55, 1'b1, BIT);
      begin
        lat_cnt = 0;
        while (!bus.rx_ready && lat_cnt < 2000) begin
          cyc(1);
          lat_cnt++;
        end
      end
    join
    chk("latency", (lat_cnt >= 1522 && lat_cnt <= 1524) ? 1523 : lat_cnt, 1523);
    model_good(8'h55);
    cyc(5);
    check_all("f55");
    do_rd();
    cyc(50);

    // 40-cycle low glitch is rejected, next frame still received
    UART_RX = 1'b0;
    cyc(40);
    UART_RX = 1'b1;
    cyc(300);
    check_all("glitch");
    send_frame(8'h3C, 1'b1, BIT);
    model_good(8'h3C);
    cyc(5);
    check_all("f3c");
    do_rd();
    cyc(50);

    // bad stop bit, line held low, then recovery frame
    send_frame(8'hA3, 1'b0, BIT);
    cyc(400);
    model_bad();
    check_all("break");
    UART_RX = 1'b1;
    cyc(200);
    send_frame(8'h0F, 1'b1, BIT);
    model_good(8'h0F);
    cyc(5);
    check_all("f0f");
    do_rd();
    cyc(5);
    check_all("f0f_rd");
    cyc(50);

    // back-to-back frames without a read produce overrun
    send_frame(8'h11, 1'b1, BIT);
    model_good(8'h11);
    send_frame(8'h22, 1'b1, BIT);
    model_good(8'h22);
    cyc(5);
    check_all("ovr");
    do_rd();
    cyc(5);
    check_all("ovr_rd");
    cyc(50);

    // read acknowledge in the same cycle the next byte completes
    send_frame(8'h5A, 1'b1, BIT);
    model_good(8'h5A);
    cyc(30);
    fork
      send_frame(8'h99, 1'b1, BIT);
      begin
        cyc(1522);
        bus.rd = 1'b1;
        cyc(1);
        bus.rd = 1'b0;
      end
    join
    model_rd();
    model_good(8'h99);
    cyc(5);
    check_all("rd_coll");
    cyc(50);

    // reset in the middle of a frame
    UART_RX = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      UART_RX = i[0];
      cyc(BIT);
    end
    reset   = 1'b1;
    UART_RX = 1'b1;
    cyc(3);
    model_reset();
    check_all("midrst");
    reset = 1'b0;
    cyc(300);
    check_all("postrst");
    send_frame(8'hC4, 1'b1, BIT);
    model_good(8'hC4);
    cyc(5);
    check_all("fc4");
    do_rd();
    cyc(50);

    // randomized frames: data, stop validity, baud skew up to 2.5%, gaps, reads
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      logic       good;
      int         period;
      b      = 8'($urandom);
      good   = ($urandom_range(0, 4) != 0);
      period = $urandom_range(156, 164);
      if ($urandom_range(0, 1) == 1) do_rd();
      cyc($urandom_range(0, 50));
      send_frame(b, good, period);
      if (good) begin
        model_good(b);
      end else begin
        cyc($urandom_range(0, 200));
        model_bad();
        UART_RX = 1'b1;
        cyc(20);
      end
      cyc(2);
      check_all($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Receive front end for the serial link into the processor. Samples `UART_RX` at 16x baud, frames 8N1 characters and holds one received byte for the processor's peripheral read path. Exposes ready, framing-error and overrun status with a single-cycle read acknowledge. Clocked from `sysclk`, the undivided board clock, so baud timing does not depend on the divided core clock.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, frequency of `sysclk` in Hz
- `BAUD`, 9600, line rate in bit/s
- `DIV`, CLK_HZ/(BAUD*16) (integer floor, 651 at defaults), sysclk cycles per oversample tick

Ports:
- `sysclk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `UART_RX` in 1: asynchronous serial input, idle high.
- `rd` in 1: one-cycle read acknowledge from the processor.
- `rx_data` out 8: last accepted byte.
- `rx_ready` out 1: a byte is waiting in `rx_data`.
- `frame_err` out 1: sticky; a stop bit sampled low.
- `overrun` out 1: sticky; a byte completed while `rx_ready` was already 1.

## Operation
- Synchronizer: 2-flop chain on `UART_RX`, reset value 1. All logic uses the synchronized value `rxs`.
- Tick divider:
  - `tcnt` counts 0..DIV-1; `tick` is asserted when `tcnt==DIV-1`, then `tcnt` wraps to 0.
  - `tcnt` is cleared on the IDLE->START transition.
- Sample counter `scnt` (4 bits) advances on each `tick`. Bit counter `bcnt` runs 0..7.
- States:
  - IDLE: `rxs==0` -> START, with `tcnt=0` and `scnt=0`.
  - START: when `scnt` reaches 7 on a tick (8th tick), check `rxs`. If 1, treat as a glitch and go to IDLE. If 0, go to DATA with `scnt=0` and `bcnt=0`.
  - DATA: on every 16th tick (`scnt==15` on tick), shift `rxs` into bit `bcnt` (LSB first). After bit 7, go to STOP.
  - STOP: on the 16th tick, sample `rxs`.
    - 1: load `rx_data` from the shift register, set `rx_ready`, go to IDLE.
    - 0: set `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs==1`, then go to IDLE. No start bit is detected while the line stays low.
- Read/status rules:
  - `rd` clears `rx_ready`, `frame_err` and `overrun` on the next edge. `rx_data` is unchanged.
  - Byte completes while `rx_ready==1` and `rd==0`: `rx_data` is overwritten with the new byte, `overrun` is set, `rx_ready` stays 1.
  - Byte completes in the same cycle as `rd`: completion wins. `rx_ready=1`, `rx_data` = new byte, `overrun` is cleared (not set).
  - Framing error in the same cycle as `rd`: `frame_err` ends at 1.
  - `rd` while `rx_ready==0` is harmless; it clears only the sticky flags.
- Reset at any point, mid-frame included:
  - State -> IDLE; `tcnt`, `scnt`, `bcnt` and the shift register -> 0; synchronizer -> 1.
  - `rx_data=0x00`, `rx_ready=0`, `frame_err=0`, `overrun=0`.

## Timing
- Every output is registered. Reset values: all outputs 0.
- Synchronizer latency: 2 cycles from the `UART_RX` edge to `rxs`.
- Sample points: start check at the mid-start-bit (tick 8). Data bit n is sampled at tick 8+16(n+1); the stop bit at tick 152, counted from the START entry.
- `rx_ready` rises the cycle after the stop sample tick: 152*DIV + 3 cycles after the falling `UART_RX` edge (±1 cycle for edge phase).
- Tolerates ±3% baud mismatch. Back-to-back frames (stop bit followed immediately by the next start) are received without loss.
- No combinational path from `rd` or `UART_RX` to any output.

## Test plan
All scenarios use CLK_HZ=1_600_000, BAUD=10_000, so DIV=10 and one bit = 160 cycles.
- Frame 0x55 (start, 8 data, stop=1) -> `rx_data=0x55`, `rx_ready=1`, `frame_err=0`, `overrun=0`, with `rx_ready` rising at 1523±1 cycles after the start edge.
- Low glitch of 40 cycles, then line high -> state returns to IDLE, `rx_ready` stays 0, no flags set. A following frame 0x3C is received correctly.
- Frame 0xA3 with stop bit 0, line held low for 400 more cycles, then high, then frame 0x0F:
  - after the bad stop bit: `frame_err=1`, `rx_ready=0`, no reception during the low period;
  - after 0x0F: `rx_data=0x0F`, `rx_ready=1`, `frame_err` still 1 until `rd`.
- Frames 0x11 then 0x22 back-to-back with no `rd` -> `rx_data=0x22`, `rx_ready=1`, `overrun=1`. One-cycle `rd` -> `rx_ready=0`, `overrun=0`, `rx_data` stays 0x22.
- `rd` pulsed exactly in the stop-sample completion cycle of frame 0x99 while a prior byte is pending -> `rx_data=0x99`, `rx_ready=1`, `overrun=0`.
- `reset` asserted after 4 data bits of a frame, released, then frame 0xC4 sent:
  - during reset: all outputs 0;
  - afterwards: `rx_data=0xC4`, `rx_ready=1`, no flags.
